ept_wire_arb: RTL and testbench

EPT_WIRE_ARB -- requirements
Module: ept_wire_arb

---
 rtl/ept_wire_arb.sv | 193 +++++++++++++++++++
 tb/tb_ept_wire_arb.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ept_wire_arb.sv
// ept_wire_arb: merges N user-channel buses onto one Active Transfer bus,
// as a registered wire-OR (MODE 0) or a round-robin owned mux (MODE 1).
// Ports: clk; reset_n (synchronous, active-low); uc_out_m[N*W] channel
//   buses, channel i at [i*W +: W]; req[N] requests (mode 1 only);
//   grant[N] owner one-hot (all-ones in mode 0); uc_out[W]/uc_valid
//   registered combined bus; collision registered pulse; coll_count[16]
//   saturating collision counter.
// Build option: define EPT_WIRE_ARB_COLL_CNT_EN to include coll_count;
//   when undefined coll_count is tied to zero.
module ept_wire_arb #(
    parameter int N        = 2,
    parameter int W        = 30,
    parameter int MODE     = 0,
    parameter int HOLD_MAX = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N*W-1:0] uc_out_m,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [W-1:0]   uc_out,
    output logic           uc_valid,
    output logic           collision,
    output logic [15:0]    coll_count
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    logic [W-1:0] ch [N];

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign ch[i] = uc_out_m[i*W +: W];
    end

    if (MODE == 0) begin : g_or
        logic [W-1:0] or_all;
        logic         multi;
        logic         seen;
        logic         unused_req;

        assign unused_req = ^req;

        // multi flags two or more non-zero channels in the same cycle
        always_comb begin
            or_all = '0;
            multi  = 1'b0;
            seen   = 1'b0;
            for (int i = 0; i < N; i++) begin
                or_all = or_all | ch[i];
                if (|ch[i]) begin
                    if (seen)
                        multi = 1'b1;
                    seen = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                grant     <= '0;
                uc_out    <= '0;
                uc_valid  <= 1'b0;
                collision <= 1'b0;
            end else begin
                grant     <= '1;
                uc_out    <= or_all;
                uc_valid  <= 1'b1;
                collision <= multi;
            end
        end
    end else begin : g_rr
        localparam int PW = (N > 1) ? $clog2(N) : 1;
        localparam int TW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
        localparam logic [TW-1:0] TMAX =
            (HOLD_MAX > 0) ? TW'(HOLD_MAX) : '1;

        state_t         state;
        state_t         state_nx;
        logic [PW-1:0]  ptr;
        logic [PW-1:0]  ptr_nx;
        logic [PW-1:0]  owner;
        logic [PW-1:0]  owner_nx;
        logic [PW-1:0]  nxt_own;
        logic [PW-1:0]  start;
        logic [PW-1:0]  pick;
        logic [TW-1:0]  tenure;
        logic [TW-1:0]  tenure_nx;
        logic [N-1:0]   own_oh;
        logic [N-1:0]   others;
        logic [N-1:0]   vec;
        logic [2*N-1:0] dbl;
        logic           found;
        logic           rot;

        assign nxt_own = (int'(owner) == N - 1) ? '0 : owner + 1'b1;

        // Round-robin search: rotate the candidate vector so that bit 0
        // is the search start, then take the lowest set bit.  In OWN the
        // search starts just past the owner and ignores the owner itself.
        always_comb begin
            own_oh        = '0;
            own_oh[owner] = 1'b1;
            others        = req & ~own_oh;
            vec           = (state == OWN) ? others : req;
            start         = (state == OWN) ? nxt_own : ptr;
            dbl           = {vec, vec} >> start;
            found         = 1'b0;
            pick          = '0;
            for (int k = 0; k < N; k++) begin
                if (!found && dbl[k]) begin
                    found = 1'b1;
                    pick  = PW'((int'(start) + k) % N);
                end
            end
        end

        always_comb begin
            state_nx  = state;
            ptr_nx    = ptr;
            owner_nx  = owner;
            tenure_nx = tenure;
            rot       = 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state_nx  = OWN;
                        owner_nx  = pick;
                        tenure_nx = TW'(1);
                    end
                end
                OWN: begin
                    if (!req[owner]) begin
                        ptr_nx = nxt_own;
                        if (found) begin
                            owner_nx  = pick;
                            tenure_nx = TW'(1);
                        end else begin
                            state_nx  = IDLE;
                            tenure_nx = '0;
                        end
                    end else if (HOLD_MAX > 0 && tenure == TMAX
                                 && |others) begin
                        // tenure expired with a waiter: forced hand-over
                        rot       = 1'b1;
                        ptr_nx    = nxt_own;
                        owner_nx  = pick;
                        tenure_nx = TW'(1);
                    end else if (tenure != TMAX) begin
                        tenure_nx = tenure + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state     <= IDLE;
                ptr       <= '0;
                owner     <= '0;
                tenure    <= '0;
                uc_out    <= '0;
                uc_valid  <= 1'b0;
                collision <= 1'b0;
            end else begin
                state     <= state_nx;
                ptr       <= ptr_nx;
                owner     <= owner_nx;
                tenure    <= tenure_nx;
                uc_out    <= (state == OWN) ? ch[owner] : '0;
                uc_valid  <= (state == OWN);
                collision <= rot;
            end
        end

        assign grant = (state == OWN) ? own_oh : '0;
    end

`ifdef EPT_WIRE_ARB_COLL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            coll_count <= '0;
        else if (collision && coll_count != 16'hFFFF)
            coll_count <= coll_count + 16'd1;
    end
`else
    assign coll_count = 16'h0;
`endif

endmodule

// File: tb/tb_ept_wire_arb.sv
// tb_ept_wire_arb: randomized and directed bench for ept_wire_arb,
// covering mode 0 and several mode 1 configurations against a model.
module tb_ept_wire_arb;

`ifdef EPT_WIRE_ARB_COLL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    // d0: mode 0, N=3, W=30
    logic [89:0] a_bus = '0;
    logic [2:0]  a_req = '0;
    logic [2:0]  a_grant;
    logic [29:0] a_out;
    logic        a_vld, a_coll;
    logic [15:0] a_cnt;
    // d1: mode 1, N=4, W=8, unlimited tenure
    logic [31:0] b_bus = '0;
    logic [3:0]  b_req = '0;
    logic [3:0]  b_grant;
    logic [7:0]  b_out;
    logic        b_vld, b_coll;
    logic [15:0] b_cnt;
    // d2: mode 1, N=2, W=8, HOLD_MAX=3
    logic [15:0] c_bus = '0;
    logic [1:0]  c_req = '0;
    logic [1:0]  c_grant;
    logic [7:0]  c_out;
    logic        c_vld, c_coll;
    logic [15:0] c_cnt;
    // d3: mode 1, N=1, W=8, HOLD_MAX=2
    logic [7:0]  e_bus = '0;
    logic [0:0]  e_req = '0;
    logic [0:0]  e_grant;
    logic [7:0]  e_out;
    logic        e_vld, e_coll;
    logic [15:0] e_cnt;

    ept_wire_arb #(.N(3), .W(30), .MODE(0), .HOLD_MAX(0)) d0 (
        .clk(clk), .reset_n(reset_n), .uc_out_m(a_bus), .req(a_req),
        .grant(a_grant), .uc_out(a_out), .uc_valid(a_vld),
        .collision(a_coll), .coll_count(a_cnt));
    ept_wire_arb #(.N(4), .W(8), .MODE(1), .HOLD_MAX(0)) d1 (
        .clk(clk), .reset_n(reset_n), .uc_out_m(b_bus), .req(b_req),
        .grant(b_grant), .uc_out(b_out), .uc_valid(b_vld),
        .collision(b_coll), .coll_count(b_cnt));
    ept_wire_arb #(.N(2), .W(8), .MODE(1), .HOLD_MAX(3)) d2 (
        .clk(clk), .reset_n(reset_n), .uc_out_m(c_bus), .req(c_req),
        .grant(c_grant), .uc_out(c_out), .uc_valid(c_vld),
        .collision(c_coll), .coll_count(c_cnt));
    ept_wire_arb #(.N(1), .W(8), .MODE(1), .HOLD_MAX(2)) d3 (
        .clk(clk), .reset_n(reset_n), .uc_out_m(e_bus), .req(e_req),
        .grant(e_grant), .uc_out(e_out), .uc_valid(e_vld),
        .collision(e_coll), .coll_count(e_cnt));

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  grant;
        logic [29:0] out;
        bit          vld;
        bit          coll;
        int          cnt;
    } or_t;

    typedef struct {
        bit         own;
        int         owner;
        int         ptr;
        int         ten;
        logic [7:0] out;
        bit         vld;
        bit         coll;
        int         cnt;
    } rr_t;

    or_t ma = '{default: 0};
    rr_t mb = '{default: 0};
    rr_t mc = '{default: 0};
    rr_t me = '{default: 0};

    function automatic int next_cnt(bit coll, int cnt);
        if (CNT_EN && coll && cnt < 65535)
            return cnt + 1;
        return cnt;
    endfunction

    function automatic or_t or_step(or_t s, bit rn, logic [89:0] bus);
        or_t x;
        int  nz;
        if (!rn)
            return '{default: 0};
        x  = s;
        nz = 0;
        x.out = bus[29:0] | bus[59:30] | bus[89:60];
        for (int k = 0; k < 3; k++)
            if (bus[k*30 +: 30] != 30'h0)
                nz++;
        x.coll  = (nz >= 2);
        x.grant = 3'b111;
        x.vld   = 1'b1;
        x.cnt   = next_cnt(s.coll, s.cnt);
        return x;
    endfunction

    // first requester at or after start (mod n), never returning skip
    function automatic int first_req(logic [3:0] r, int n,
                                     int start, int skip);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (j != skip && r[j])
                return j;
        end
        return -1;
    endfunction

    function automatic rr_t rr_step(rr_t s, bit rn, int n, int hold,
                                    logic [3:0] r, logic [31:0] bus);
        rr_t x;
        if (!rn)
            return '{default: 0};
        x      = s;
        x.out  = s.own ? bus[s.owner*8 +: 8] : 8'h0;
        x.vld  = s.own;
        x.coll = 1'b0;
        x.cnt  = next_cnt(s.coll, s.cnt);
        if (!s.own) begin
            x.owner = first_req(r, n, s.ptr, -1);
            if (x.owner >= 0) begin
                x.own = 1'b1;
                x.ten = 1;
            end else begin
                x.owner = s.owner;
            end
        end else if (!r[s.owner]) begin
            x.ptr   = (s.owner + 1) % n;
            x.owner = first_req(r, n, x.ptr, s.owner);
            if (x.owner < 0) begin
                x.own   = 1'b0;
                x.owner = 0;
                x.ten   = 0;
            end else begin
                x.ten = 1;
            end
        end else if (hold > 0 && s.ten >= hold
                     && first_req(r, n, 0, s.owner) >= 0) begin
            x.coll  = 1'b1;
            x.ptr   = (s.owner + 1) % n;
            x.owner = first_req(r, n, x.ptr, s.owner);
            x.ten   = 1;
        end else begin
            x.ten = s.ten + 1;
        end
        return x;
    endfunction

    function automatic logic [50:0] or_pack(or_t s);
        return {s.grant, s.out, s.vld, s.coll, 16'(s.cnt)};
    endfunction

    function automatic logic [29:0] rr_pack(rr_t s);
        logic [3:0] g;
        g = s.own ? 4'(1 << s.owner) : 4'h0;
        return {g, s.out, s.vld, s.coll, 16'(s.cnt)};
    endfunction

    always @(posedge clk) begin
        ma = or_step(ma, reset_n, a_bus);
        mb = rr_step(mb, reset_n, 4, 0, b_req, b_bus);
        mc = rr_step(mc, reset_n, 2, 3, {2'b0, c_req}, {16'h0, c_bus});
        me = rr_step(me, reset_n, 1, 2, {3'b0, e_req}, {24'h0, e_bus});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        a_bus = {30'($urandom()), 30'($urandom()), 30'($urandom())};
        b_req = 4'hF;
        c_req = 2'h3;
        e_req = 1'b1;
        b_bus = $urandom();
        repeat (3) begin
            tick();
            total++;
            if ({a_grant, a_out, a_vld, a_coll, a_cnt} !== 51'h0)
                $display("FAIL reset_d0: got %h expected 0",
                         {a_grant, a_out, a_vld, a_coll, a_cnt});
            else passed++;
            total++;
            if ({b_grant, b_out, b_vld, b_coll, b_cnt} !== 30'h0)
                $display("FAIL reset_d1: got %h expected 0",
                         {b_grant, b_out, b_vld, b_coll, b_cnt});
            else passed++;
            total++;
            if ({c_grant, c_out, c_vld, c_coll, c_cnt} !== 28'h0)
                $display("FAIL reset_d2: got %h expected 0",
                         {c_grant, c_out, c_vld, c_coll, c_cnt});
            else passed++;
            total++;
            if ({e_grant, e_out, e_vld, e_coll, e_cnt} !== 27'h0)
                $display("FAIL reset_d3: got %h expected 0",
                         {e_grant, e_out, e_vld, e_coll, e_cnt});
            else passed++;
        end
        a_bus = '0;
        b_req = '0;
        c_req = '0;
        e_req = '0;
        reset_n = 1'b1;
        tick();
        total++;
        if ({a_grant, a_vld} !== 4'b1111)
            $display("FAIL mode0_release: grant/valid got %b expected 1111",
                     {a_grant, a_vld});
        else passed++;
        total++;
        if (b_grant !== 4'h0)
            $display("FAIL rr_release_idle: grant got %b expected 0000",
                     b_grant);
        else passed++;
    endtask

    task automatic test_or_directed();
        a_bus = {30'h4, 30'h2, 30'h1};
        tick();
        total++;
        if ({a_out, a_coll, a_cnt} !== {30'h7, 1'b1, 16'h0})
            $display("FAIL or_three: out/coll/cnt got %h/%b/%h exp 7/1/0",
                     a_out, a_coll, a_cnt);
        else passed++;
        a_bus = '0;
        tick();
        total++;
        if ({a_out, a_coll, a_cnt} !== {30'h0, 1'b0, CNT_EN ? 16'h1 : 16'h0})
            $display("FAIL or_after: out/coll/cnt got %h/%b/%h exp 0/0/%0d",
                     a_out, a_coll, a_cnt, CNT_EN);
        else passed++;
        a_bus = {30'h0, 30'h0, 30'h2A};
        tick();
        total++;
        if ({a_out, a_coll} !== {30'h2A, 1'b0})
            $display("FAIL or_single: out/coll got %h/%b expected 2a/0",
                     a_out, a_coll);
        else passed++;
    endtask

    task automatic test_or_random();
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 3; k++)
                a_bus[k*30 +: 30] =
                    ($urandom_range(1) == 0) ? 30'h0 : 30'($urandom());
            tick();
            total++;
            if ({a_grant, a_out, a_vld, a_coll, a_cnt} !== or_pack(ma))
                $display("FAIL or_random: got %h expected %h",
                         {a_grant, a_out, a_vld, a_coll, a_cnt},
                         or_pack(ma));
            else passed++;
        end
        a_bus = '0;
    endtask

    task automatic test_rr_handover();
        b_bus = 32'h44_33_22_11;
        b_req = 4'b1010;
        tick();
        total++;
        if (b_grant !== 4'b0010)
            $display("FAIL rr_first: grant got %b expected 0010", b_grant);
        else passed++;
        b_req = 4'b1000;
        tick();
        total++;
        if ({b_grant, b_out, b_vld} !== {4'b1000, 8'h22, 1'b1})
            $display("FAIL rr_handover: grant/out/vld got %b/%h/%b exp 1000/22/1",
                     b_grant, b_out, b_vld);
        else passed++;
        tick();
        total++;
        if ({b_grant, b_out, b_vld, b_coll} !== {4'b1000, 8'h44, 1'b1, 1'b0})
            $display("FAIL rr_data: got %b/%h/%b/%b exp 1000/44/1/0",
                     b_grant, b_out, b_vld, b_coll);
        else passed++;
        b_req = 4'b0000;
        tick();
        total++;
        if (b_grant !== 4'b0000)
            $display("FAIL rr_idle: grant got %b expected 0000", b_grant);
        else passed++;
        tick();
    endtask

    task automatic test_rr_timeout();
        logic [1:0] eg;
        logic       ec;
        c_bus = 16'hBBAA;
        c_req = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            tick();
            eg = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            ec = (k == 4 || k == 7);
            total++;
            if ({c_grant, c_coll} !== {eg, ec})
                $display("FAIL rr_timeout_%0d: grant/coll got %b/%b exp %b/%b",
                         k, c_grant, c_coll, eg, ec);
            else passed++;
            total++;
            if ({2'b00, c_grant, c_out, c_vld, c_coll, c_cnt} !== rr_pack(mc))
                $display("FAIL rr_timeout_model: got %h expected %h",
                         {2'b00, c_grant, c_out, c_vld, c_coll, c_cnt},
                         rr_pack(mc));
            else passed++;
        end
        c_req = 2'b01;
        repeat (8) tick();
        total++;
        if ({c_grant, c_coll, c_out} !== {2'b01, 1'b0, 8'hAA})
            $display("FAIL rr_sole_owner: got %b/%b/%h exp 01/0/aa",
                     c_grant, c_coll, c_out);
        else passed++;
        c_req = 2'b00;
        tick();
    endtask

    task automatic test_n1();
        e_bus = 8'h5C;
        e_req = 1'b1;
        tick();
        total++;
        if (e_grant !== 1'b1)
            $display("FAIL n1_grant: got %b expected 1", e_grant);
        else passed++;
        repeat (4) tick();
        total++;
        if ({e_grant, e_out, e_vld, e_coll} !== {1'b1, 8'h5C, 1'b1, 1'b0})
            $display("FAIL n1_hold: got %b/%h/%b/%b exp 1/5c/1/0",
                     e_grant, e_out, e_vld, e_coll);
        else passed++;
        e_req = 1'b0;
        tick();
        total++;
        if (e_grant !== 1'b0)
            $display("FAIL n1_release: got %b expected 0", e_grant);
        else passed++;
    endtask

    task automatic test_rr_reset_mid();
        int t;
        b_bus = 32'h0F_0E_0D_0C;
        b_req = 4'b0100;
        t = 0;
        do begin
            tick();
            t++;
        end while (b_grant !== 4'b0100 && t < 8);
        total++;
        if (b_grant !== 4'b0100)
            $display("FAIL rr_wait_ch2: grant got %b expected 0100 (timeout)",
                     b_grant);
        else passed++;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        total++;
        if ({b_grant, b_out, b_vld} !== 13'h0)
            $display("FAIL rr_mid_reset: grant/out/vld got %b/%h/%b exp 0/0/0",
                     b_grant, b_out, b_vld);
        else passed++;
        reset_n = 1'b1;
        b_req = 4'b1111;
        tick();
        total++;
        if (b_grant !== 4'b0001)
            $display("FAIL rr_restart: grant got %b expected 0001", b_grant);
        else passed++;
    endtask

    task automatic test_rr_random();
        for (int i = 0; i < 400; i++) begin
            b_bus = $urandom();
            c_bus = 16'($urandom());
            e_bus = 8'($urandom());
            if ($urandom_range(3) == 0) b_req = 4'($urandom());
            if ($urandom_range(3) == 0) c_req = 2'($urandom());
            if ($urandom_range(5) == 0) e_req = 1'($urandom());
            tick();
            total++;
            if ({b_grant, b_out, b_vld, b_coll, b_cnt} !== rr_pack(mb))
                $display("FAIL rr_random_d1: got %h expected %h",
                         {b_grant, b_out, b_vld, b_coll, b_cnt}, rr_pack(mb));
            else passed++;
            total++;
            if ({2'b00, c_grant, c_out, c_vld, c_coll, c_cnt} !== rr_pack(mc))
                $display("FAIL rr_random_d2: got %h expected %h",
                         {2'b00, c_grant, c_out, c_vld, c_coll, c_cnt},
                         rr_pack(mc));
            else passed++;
            total++;
            if ({3'b000, e_grant, e_out, e_vld, e_coll, e_cnt} !== rr_pack(me))
                $display("FAIL rr_random_d3: got %h expected %h",
                         {3'b000, e_grant, e_out, e_vld, e_coll, e_cnt},
                         rr_pack(me));
            else passed++;
        end
        b_req = '0;
        c_req = '0;
        e_req = '0;
    endtask

    task automatic test_saturate();
        a_bus = {30'h0, 30'h5, 30'h3};
        repeat (70000) @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            total++;
            if (a_cnt !== (CNT_EN ? 16'hFFFF : 16'h0))
                $display("FAIL coll_saturate_%0d: got %h expected %h",
                         r, a_cnt, CNT_EN ? 16'hFFFF : 16'h0);
            else passed++;
            total++;
            if ({a_grant, a_out, a_vld, a_coll, a_cnt} !== or_pack(ma))
                $display("FAIL coll_saturate_model: got %h expected %h",
                         {a_grant, a_out, a_vld, a_coll, a_cnt},
                         or_pack(ma));
            else passed++;
            tick();
        end
        a_bus = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_or_directed();
        test_or_random();
        test_rr_handover();
        test_rr_timeout();
        test_n1();
        test_rr_reset_mid();
        test_rr_random();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
